// File: rtl/vend_pay_ctrl.sv
// rtl/vend_pay_ctrl.sv - payment collection, vend strobe and greedy change return
//
// Ports:
//   i_clk, i_rst_n                   clock, asynchronous active-low reset
//   i_total_valid, i_total[15:0]     order total from the multiplier (pulse)
//   i_coin_valid, i_coin[1:0]        inserted coin (0:10 1:50 2:100 3:500)
//   o_coin_ready                     coins accepted while collecting
//   i_cancel                         abort order, refund everything paid
//   o_paid[15:0]                     running paid sum (saturating)
//   o_vend                           one-cycle vend strobe
//   o_change_valid, o_change_coin    change coin offer, held until i_change_ready
//   i_change_ready                   dispenser takes the offered coin
//   o_done, o_remainder[15:0]        completion pulse, unpayable change (<10)
module vend_pay_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_total_valid,
  input  logic [15:0] i_total,
  input  logic        i_coin_valid,
  input  logic [1:0]  i_coin,
  output logic        o_coin_ready,
  input  logic        i_cancel,
  output logic [15:0] o_paid,
  output logic        o_vend,
  output logic        o_change_valid,
  output logic [1:0]  o_change_coin,
  input  logic        i_change_ready,
  output logic        o_done,
  output logic [15:0] o_remainder
);

  typedef enum logic [2:0] {IDLE, COLLECT, VEND, CHANGE, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] total_q;
  logic [15:0] change_q;
  logic [15:0] coin_amt;
  logic [16:0] sum_wide;
  logic [15:0] paid_sum;
  logic        coin_take;
  logic        covered;
  logic        has_offer;
  logic [1:0]  offer_code;
  logic [15:0] offer_amt;
  logic [15:0] change_left;

  always_comb begin
    unique case (i_coin)
      2'd0:    coin_amt = 16'd10;
      2'd1:    coin_amt = 16'd50;
      2'd2:    coin_amt = 16'd100;
      default: coin_amt = 16'd500;
    endcase
  end

  assign coin_take = (state == COLLECT) && i_coin_valid;
  assign sum_wide  = {1'b0, o_paid} + {1'b0, (coin_take ? coin_amt : 16'd0)};
  assign paid_sum  = sum_wide[16] ? 16'hFFFF : sum_wide[15:0];
  // Coverage uses the registered sum, so a covering coin vends one cycle later.
  assign covered   = (o_paid >= total_q);

  // Greedy offer is recomputed from the registered change, so it stays
  // stable while the dispenser stalls.
  always_comb begin
    has_offer  = 1'b1;
    offer_code = 2'd0;
    offer_amt  = 16'd10;
    if (change_q >= 16'd500) begin
      offer_code = 2'd3;
      offer_amt  = 16'd500;
    end else if (change_q >= 16'd100) begin
      offer_code = 2'd2;
      offer_amt  = 16'd100;
    end else if (change_q >= 16'd50) begin
      offer_code = 2'd1;
      offer_amt  = 16'd50;
    end else if (change_q < 16'd10) begin
      has_offer  = 1'b0;
      offer_amt  = 16'd0;
    end
  end

  assign change_left = change_q - offer_amt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    o_coin_ready   = 1'b0;
    o_vend         = 1'b0;
    o_change_valid = 1'b0;
    o_change_coin  = 2'd0;
    o_done         = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_total_valid) state_nxt = COLLECT;
      end
      COLLECT: begin
        o_coin_ready = 1'b1;
        if (covered)       state_nxt = VEND;
        else if (i_cancel) state_nxt = CHANGE;
      end
      VEND: begin
        o_vend    = 1'b1;
        state_nxt = CHANGE;
      end
      CHANGE: begin
        if (!has_offer) begin
          state_nxt = DONE;
        end else begin
          o_change_valid = 1'b1;
          o_change_coin  = offer_code;
          // Skip the idle CHANGE cycle once the last payable coin leaves.
          if (i_change_ready && (change_left < 16'd10)) state_nxt = DONE;
        end
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      total_q     <= 16'd0;
      change_q    <= 16'd0;
      o_paid      <= 16'd0;
      o_remainder <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_total_valid) begin
            total_q     <= i_total;
            o_paid      <= 16'd0;
            o_remainder <= 16'd0;
          end
        end
        COLLECT: begin
          o_paid <= paid_sum;
          if (!covered && i_cancel) change_q <= paid_sum;
        end
        VEND: begin
          change_q <= o_paid - total_q;
        end
        CHANGE: begin
          if (!has_offer) begin
            o_remainder <= change_q;
          end else if (i_change_ready) begin
            change_q <= change_left;
            if (change_left < 16'd10) o_remainder <= change_left;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_pay_ctrl.sv
// tb/tb_vend_pay_ctrl.sv - scoreboard bench for vend_pay_ctrl
module tb_vend_pay_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_total_valid;
  logic [15:0] i_total;
  logic        i_coin_valid;
  logic [1:0]  i_coin;
  logic        o_coin_ready;
  logic        i_cancel;
  logic [15:0] o_paid;
  logic        o_vend;
  logic        o_change_valid;
  logic [1:0]  o_change_coin;
  logic        i_change_ready;
  logic        o_done;
  logic [15:0] o_remainder;

  always #5 i_clk = ~i_clk;

  vend_pay_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_total_valid(i_total_valid), .i_total(i_total),
    .i_coin_valid(i_coin_valid), .i_coin(i_coin), .o_coin_ready(o_coin_ready),
    .i_cancel(i_cancel), .o_paid(o_paid), .o_vend(o_vend),
    .o_change_valid(o_change_valid), .o_change_coin(o_change_coin),
    .i_change_ready(i_change_ready), .o_done(o_done), .o_remainder(o_remainder)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  int exp_q[$];
  int cyc = 0, vend_cnt = 0, done_cnt = 0, n_xfer = 0;
  int vend_cyc = 0, done_cyc = 0, last_xfer_cyc = 0, rem_at_done = 0;
  bit stalled = 0;
  int held_coin = 0;

  // Monitor: pops the scoreboard on each change handshake.
  initial forever begin
    @(negedge i_clk);
    cyc++;
    if (!i_rst_n) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        check_eq("held_valid", int'(o_change_valid), 1);
        check_eq("held_coin", int'(o_change_coin), held_coin);
      end
      stalled   = o_change_valid && !i_change_ready;
      held_coin = int'(o_change_coin);
      if (o_vend) begin vend_cnt++; vend_cyc = cyc; end
      if (o_done) begin done_cnt++; done_cyc = cyc; rem_at_done = int'(o_remainder); end
      if (o_change_valid && i_change_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_change", int'(o_change_coin), -1);
        else check_eq("change_coin", int'(o_change_coin), exp_q.pop_front());
        n_xfer++;
        last_xfer_cyc = cyc;
      end
    end
  end

  int val_of[4] = '{10, 50, 100, 500};
  int exp_paid, exp_vend, exp_rem;
  int vend_base, done_base, xfer_base;

  // Drives one order's payment phase and pushes the expected change coins.
  task automatic collect(input int total, input int coins[5], input int n,
                         input bit cancel, input int extra);
    int chg;
    vend_base = vend_cnt;
    done_base = done_cnt;
    xfer_base = n_xfer;
    @(posedge i_clk); #1;
    i_total_valid = 1'b1;
    i_total = 16'(total);
    @(posedge i_clk); #1;
    i_total_valid = 1'b0;
    check_eq("coin_ready", int'(o_coin_ready), 1);
    check_eq("paid_cleared", int'(o_paid), 0);
    exp_paid = 0;
    for (int i = 0; i < n; i++) begin
      i_coin_valid = 1'b1;
      i_coin = 2'(coins[i]);
      @(posedge i_clk); #1;
      exp_paid = exp_paid + val_of[coins[i]];
      if (exp_paid > 65535) exp_paid = 65535;
    end
    i_coin_valid = 1'b0;
    exp_vend = (exp_paid >= total) ? 1 : 0;
    if (extra >= 0) begin
      i_coin_valid = 1'b1;
      i_coin = 2'(extra);
      i_cancel = 1'b1;
      @(posedge i_clk); #1;
      i_coin_valid = 1'b0;
      i_cancel = 1'b0;
      exp_paid = exp_paid + val_of[extra];
    end else if (cancel) begin
      i_cancel = 1'b1;
      @(posedge i_clk); #1;
      i_cancel = 1'b0;
    end
    check_eq("paid", int'(o_paid), exp_paid);
    chg = exp_vend ? exp_paid - total : exp_paid;
    while (chg >= 10) begin
      for (int k = 3; k >= 0; k--) begin
        if (chg >= val_of[k]) begin
          exp_q.push_back(k);
          chg = chg - val_of[k];
          break;
        end
      end
    end
    exp_rem = chg;
  endtask

  // Runs the change phase to completion and checks the transaction outcome.
  task automatic finish(input int stall_idx, input int stall_n);
    int guard = 0;
    int left = stall_n;
    while (done_cnt == done_base && guard < 200) begin
      @(posedge i_clk); #1;
      guard++;
      if (left > 0 && o_change_valid && (n_xfer - xfer_base) == stall_idx) begin
        i_change_ready = 1'b0;
        left--;
      end else begin
        i_change_ready = 1'b1;
      end
    end
    i_change_ready = 1'b1;
    check_eq("done_seen", int'(done_cnt > done_base), 1);
    check_eq("done_count", done_cnt - done_base, 1);
    check_eq("done_pulse_low", int'(o_done), 0);
    check_eq("vend_count", vend_cnt - vend_base, exp_vend);
    check_eq("remainder_at_done", rem_at_done, exp_rem);
    check_eq("remainder_hold", int'(o_remainder), exp_rem);
    check_eq("paid_hold", int'(o_paid), exp_paid);
    check_eq("offers_left", exp_q.size(), 0);
    if (n_xfer > xfer_base) check_eq("done_after_last_xfer", done_cyc - last_xfer_cyc, 1);
    else if (exp_vend != 0) check_eq("done_after_vend", done_cyc - vend_cyc, 2);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_paid", int'(o_paid), 0);
    check_eq("rst_vend", int'(o_vend), 0);
    check_eq("rst_change_valid", int'(o_change_valid), 0);
    check_eq("rst_change_coin", int'(o_change_coin), 0);
    check_eq("rst_done", int'(o_done), 0);
    check_eq("rst_remainder", int'(o_remainder), 0);
    check_eq("rst_coin_ready", int'(o_coin_ready), 0);
  endtask

  initial begin
    int cl[5];
    i_rst_n = 1'b0;
    i_total_valid = 1'b0;
    i_total = 16'd0;
    i_coin_valid = 1'b0;
    i_coin = 2'd0;
    i_cancel = 1'b0;
    i_change_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_outputs();
    #2 i_rst_n = 1'b1;

    cl = '{3, 3, 3, 0, 0};
    collect(1200, cl, 3, 1'b0, -1);
    finish(0, 0);

    cl = '{3, 2, 1, 0, 0};
    collect(700, cl, 3, 1'b1, -1);
    finish(0, 0);

    cl = '{2, 1, 0, 0, 0};
    collect(150, cl, 2, 1'b0, -1);
    finish(0, 0);

    cl = '{3, 3, 3, 0, 0};
    collect(1240, cl, 3, 1'b0, -1);
    finish(1, 3);

    cl = '{3, 3, 3, 0, 0};
    collect(1195, cl, 3, 1'b0, -1);
    finish(0, 0);

    cl = '{2, 0, 0, 0, 0};
    collect(100, cl, 1, 1'b0, 1);
    finish(0, 0);

    // Reset in the middle of a stalled change offer.
    i_change_ready = 1'b0;
    cl = '{3, 3, 3, 0, 0};
    collect(1195, cl, 3, 1'b0, -1);
    repeat (4) @(posedge i_clk);
    #1;
    check_eq("pre_reset_valid", int'(o_change_valid), 1);
    check_eq("pre_reset_coin", int'(o_change_coin), 2);
    #2 i_rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    repeat (2) @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;
    i_change_ready = 1'b1;

    cl = '{2, 1, 0, 0, 0};
    collect(150, cl, 2, 1'b0, -1);
    finish(0, 0);

    repeat (3) @(posedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
